ahb_lite_master: RTL

- Command-driven AHB-Lite master that converts a single command (address, direction, beat count) into a legal INCR word burst on the AHB bus.
- Sits directly upstream of the multi-slave AHB memory subsystem and drives its slave interface: HADDR, HTRANS, HWRITE, HWDATA in; HRDATA, HREADY, HRESP back.
- Handles wait states, 1KB-boundary burst splitting and error-response abort.

---
 rtl/ahb_master_pkg.sv | 28 ++
 rtl/ahb_lite_master_if.sv | 25 ++
 rtl/ahb_master_addr_gen.sv | 52 +++++
 rtl/ahb_lite_master.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_master_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the command-driven burst master.
package ahb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LAST,
    ST_ERR
  } state_t;

  // A zero-length command still moves one beat.
  function automatic int unsigned eff_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus signals between the burst master and the slave subsystem.
interface ahb_lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_master_addr_gen.sv
// Burst address counter, remaining-beat counter and 1KB boundary detect.
module ahb_master_addr_gen
  import ahb_master_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int MAX_BEATS     = 16,
  parameter int BOUNDARY_BITS = 10,
  parameter int LEN_WIDTH     = $clog2(MAX_BEATS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_beat,
  output logic                  next_boundary
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d, next_addr;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;

  assign next_addr     = addr_q + ADDR_WIDTH'(4);
  assign next_boundary = (next_addr[BOUNDARY_BITS-1:0] == '0);
  // beats_q counts address phases still to issue, including the one on the bus
  assign last_beat     = (beats_q <= LEN_WIDTH'(1));
  assign addr          = addr_q;

  always_comb begin
    addr_d  = addr_q;
    beats_d = beats_q;
    if (load) begin
      addr_d  = load_addr;
      beats_d = LEN_WIDTH'(eff_len(32'(load_len)));
    end else if (advance) begin
      addr_d  = next_addr;
      beats_d = beats_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      beats_q <= '0;
    end else begin
      addr_q  <= addr_d;
      beats_q <= beats_d;
    end
  end

endmodule

// File: rtl/ahb_lite_master.sv
// Command-driven AHB-Lite INCR burst master with wait, 1KB split and error abort.
// Optional saturating statistics counters when AHB_MASTER_STATS_EN is defined.
module ahb_lite_master
  import ahb_master_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BEATS     = 16,
  parameter int BOUNDARY_BITS = 10,
  parameter int LEN_WIDTH     = $clog2(MAX_BEATS) + 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_lite_master_if.master     ahb,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  wdata_req,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  err
`ifdef AHB_MASTER_STATS_EN
 ,output logic [31:0]           stat_beats,
  output logic [31:0]           stat_waits,
  output logic [15:0]           stat_errs
`endif
);

  state_t                state_q;
  htrans_t               htrans_q;
  logic                  hwrite_q;
  logic [2:0]            hburst_q;
  logic                  cmd_ready_q, done_q, err_q;
  logic                  rdata_valid_q, rdata_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  first_dp_q, first_dp_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic [ADDR_WIDTH-1:0] haddr;
  logic                  last_beat, next_boundary;
  logic                  addr_phase, data_phase, abort, addr_done, accept, beat_ok;

  assign addr_phase = (state_q == ST_ADDR) || (state_q == ST_BURST);
  assign data_phase = (state_q == ST_BURST) || (state_q == ST_LAST);
  assign abort      = data_phase && ahb.HRESP;
  assign addr_done  = addr_phase && ahb.HREADY && !abort;
  assign accept     = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;
  assign beat_ok    = data_phase && ahb.HREADY && !ahb.HRESP;

  ahb_master_addr_gen #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .MAX_BEATS    (MAX_BEATS),
    .BOUNDARY_BITS(BOUNDARY_BITS),
    .LEN_WIDTH    (LEN_WIDTH)
  ) u_addr_gen (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .load         (accept),
    .load_addr    (cmd_addr),
    .load_len     (cmd_len),
    .advance      (addr_done),
    .addr         (haddr),
    .last_beat    (last_beat),
    .next_boundary(next_boundary)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      htrans_q    <= IDLE;
      hwrite_q    <= 1'b0;
      hburst_q    <= HBURST_SINGLE;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready_q <= 1'b0;
            hwrite_q    <= cmd_write;
            hburst_q    <= (cmd_len <= LEN_WIDTH'(1)) ? HBURST_SINGLE : HBURST_INCR;
            htrans_q    <= NONSEQ;
            state_q     <= ST_ADDR;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_ADDR, ST_BURST: begin
          // pending address phase is dropped when the previous beat errors
          if (abort) begin
            htrans_q <= IDLE;
            state_q  <= ST_ERR;
          end else if (ahb.HREADY) begin
            if (last_beat) begin
              htrans_q <= IDLE;
              state_q  <= ST_LAST;
            end else begin
              htrans_q <= next_boundary ? NONSEQ : SEQ;
              state_q  <= ST_BURST;
            end
          end
        end
        ST_LAST: begin
          if (abort) begin
            state_q <= ST_ERR;
          end else if (ahb.HREADY) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_ERR: begin
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          htrans_q <= IDLE;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rdata_valid_d = beat_ok && !hwrite_q;
    rdata_d       = rdata_valid_d ? ahb.HRDATA : rdata_q;
    first_dp_d    = addr_done && hwrite_q;
    // live wdata is only valid in the first data-phase cycle, so keep a copy for waits
    hold_d        = first_dp_q ? wdata : hold_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      first_dp_q    <= 1'b0;
      hold_q        <= '0;
    end else begin
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
      first_dp_q    <= first_dp_d;
      hold_q        <= hold_d;
    end
  end

  assign wdata_req   = addr_done && hwrite_q;
  assign cmd_ready   = cmd_ready_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

  assign ahb.HADDR  = haddr;
  assign ahb.HTRANS = htrans_q;
  assign ahb.HWRITE = hwrite_q;
  assign ahb.HSIZE  = HSIZE_WORD;
  assign ahb.HBURST = hburst_q;
  assign ahb.HWDATA = first_dp_q ? wdata : hold_q;

`ifdef AHB_MASTER_STATS_EN
  logic [31:0] stat_beats_q, stat_beats_d;
  logic [31:0] stat_waits_q, stat_waits_d;
  logic [15:0] stat_errs_q, stat_errs_d;

  always_comb begin
    stat_beats_d = stat_beats_q;
    stat_waits_d = stat_waits_q;
    stat_errs_d  = stat_errs_q;
    if (beat_ok && (stat_beats_q != '1))
      stat_beats_d = stat_beats_q + 32'd1;
    if (data_phase && !ahb.HREADY && (stat_waits_q != '1))
      stat_waits_d = stat_waits_q + 32'd1;
    if ((state_q == ST_ERR) && (stat_errs_q != '1))
      stat_errs_d = stat_errs_q + 16'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stat_beats_q <= '0;
      stat_waits_q <= '0;
      stat_errs_q  <= '0;
    end else begin
      stat_beats_q <= stat_beats_d;
      stat_waits_q <= stat_waits_d;
      stat_errs_q  <= stat_errs_d;
    end
  end

  assign stat_beats = stat_beats_q;
  assign stat_waits = stat_waits_q;
  assign stat_errs  = stat_errs_q;
`endif

endmodule
